// File: rtl/tlb_ctrl.sv
// tlb_ctrl: single-outstanding sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// between the execute/CSR stage and the TLB array, with a valid/ready result port.
module tlb_ctrl #(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [4:0]      req_invop,
  input  logic [9:0]      req_asid,
  input  logic [31:0]     req_va,
  input  logic [10:0]     csr_tlbidx,
  input  logic [18:0]     csr_tlbehi_vppn,
  input  logic [9:0]      csr_asid,
  input  logic [26:0]     csr_elo0,
  input  logic [26:0]     csr_elo1,
  input  logic            csr_refill,
  output logic [18:0]     tlb_s_vppn,
  output logic            tlb_s_va_bit12,
  output logic [9:0]      tlb_s_asid,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry,
  output logic            tlb_invtlb_valid,
  output logic [4:0]      tlb_invtlb_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2:0]      rsp_op,
  output logic            rsp_ine,
  output logic            rsp_ne,
  output logic [IDXW-1:0] rsp_index,
  output logic [88:0]     rsp_entry
);

  localparam int unsigned OPW    = 3;
  localparam int unsigned ENTW   = 89;
  localparam int unsigned VPPNW  = 19;
  localparam int unsigned ASIDW  = 10;
  localparam int unsigned INVW   = 5;
  localparam int unsigned E_BIT  = ENTW - 1;
  localparam int unsigned NE_BIT = 10;

  localparam logic [OPW-1:0]  OP_SRCH   = 3'd0;
  localparam logic [OPW-1:0]  OP_RD     = 3'd1;
  localparam logic [OPW-1:0]  OP_WR     = 3'd2;
  localparam logic [OPW-1:0]  OP_FILL   = 3'd3;
  localparam logic [OPW-1:0]  OP_INV    = 3'd4;
  localparam logic [INVW-1:0] INVOP_MAX = 5'd6;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic            ine_q, ine_d;
  logic [IDXW-1:0] fill_q, fill_d;
  logic [ENTW-1:0] w_entry_c;

  logic             req_ready_d, s_va_bit12_d, we_d, inv_valid_d;
  logic             rsp_valid_d, rsp_ine_d, rsp_ne_d;
  logic [VPPNW-1:0] s_vppn_d;
  logic [ASIDW-1:0] s_asid_d;
  logic [IDXW-1:0]  r_index_d, w_index_d, rsp_index_d;
  logic [ENTW-1:0]  w_entry_d, rsp_entry_d;
  logic [INVW-1:0]  inv_op_d;
  logic [OPW-1:0]   rsp_op_d;

  // Entry image for WR/FILL built from the CSR snapshot taken at accept.
  assign w_entry_c = {csr_refill | ~csr_tlbidx[NE_BIT], csr_tlbidx[9:4], csr_tlbehi_vppn,
                      csr_asid, csr_elo0[6] & csr_elo1[6],
                      csr_elo0[26:7], csr_elo0[5:0], csr_elo1[26:7], csr_elo1[5:0]};

  // TLB drive values are decided at accept and registered, so they appear exactly in EXEC.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ine_d        = ine_q;
    fill_d       = fill_q + IDXW'(1);
    req_ready_d  = 1'b0;
    s_vppn_d     = '0;
    s_va_bit12_d = 1'b0;
    s_asid_d     = '0;
    r_index_d    = '0;
    we_d         = 1'b0;
    w_index_d    = '0;
    w_entry_d    = '0;
    inv_valid_d  = 1'b0;
    inv_op_d     = '0;
    rsp_valid_d  = rsp_valid;
    rsp_op_d     = rsp_op;
    rsp_ine_d    = rsp_ine;
    rsp_ne_d     = rsp_ne;
    rsp_index_d  = rsp_index;
    rsp_entry_d  = rsp_entry;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          state_d     = EXEC;
          req_ready_d = 1'b0;
          op_d        = req_op;
          ine_d       = 1'b0;
          case (req_op)
            OP_SRCH: begin
              s_vppn_d = csr_tlbehi_vppn;
              s_asid_d = csr_asid;
            end
            OP_RD:   r_index_d = csr_tlbidx[IDXW-1:0];
            OP_WR: begin
              we_d      = 1'b1;
              w_index_d = csr_tlbidx[IDXW-1:0];
              w_entry_d = w_entry_c;
            end
            OP_FILL: begin
              we_d      = 1'b1;
              w_index_d = fill_d;
              w_entry_d = w_entry_c;
            end
            OP_INV: begin
              if (req_invop <= INVOP_MAX) begin
                inv_valid_d  = 1'b1;
                inv_op_d     = req_invop;
                s_vppn_d     = req_va[31:13];
                s_va_bit12_d = req_va[12];
                s_asid_d     = req_asid;
              end else begin
                ine_d = 1'b1;
              end
            end
            default: ine_d = 1'b1;
          endcase
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_op_d    = op_q;
        rsp_ine_d   = ine_q;
        rsp_ne_d    = 1'b0;
        rsp_index_d = '0;
        rsp_entry_d = '0;
        if (op_q == OP_SRCH) begin
          rsp_ne_d    = ~tlb_s_found;
          rsp_index_d = tlb_s_found ? tlb_s_index : '0;
        end else if (op_q == OP_RD) begin
          rsp_ne_d    = ~tlb_r_entry[E_BIT];
          rsp_entry_d = tlb_r_entry[E_BIT] ? tlb_r_entry : '0;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_op_d    = '0;
          rsp_ine_d   = 1'b0;
          rsp_ne_d    = 1'b0;
          rsp_index_d = '0;
          rsp_entry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      op_q             <= '0;
      ine_q            <= 1'b0;
      fill_q           <= '0;
      req_ready        <= 1'b1;
      tlb_s_vppn       <= '0;
      tlb_s_va_bit12   <= 1'b0;
      tlb_s_asid       <= '0;
      tlb_r_index      <= '0;
      tlb_we           <= 1'b0;
      tlb_w_index      <= '0;
      tlb_w_entry      <= '0;
      tlb_invtlb_valid <= 1'b0;
      tlb_invtlb_op    <= '0;
      rsp_valid        <= 1'b0;
      rsp_op           <= '0;
      rsp_ine          <= 1'b0;
      rsp_ne           <= 1'b0;
      rsp_index        <= '0;
      rsp_entry        <= '0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      ine_q            <= ine_d;
      fill_q           <= fill_d;
      req_ready        <= req_ready_d;
      tlb_s_vppn       <= s_vppn_d;
      tlb_s_va_bit12   <= s_va_bit12_d;
      tlb_s_asid       <= s_asid_d;
      tlb_r_index      <= r_index_d;
      tlb_we           <= we_d;
      tlb_w_index      <= w_index_d;
      tlb_w_entry      <= w_entry_d;
      tlb_invtlb_valid <= inv_valid_d;
      tlb_invtlb_op    <= inv_op_d;
      rsp_valid        <= rsp_valid_d;
      rsp_op           <= rsp_op_d;
      rsp_ine          <= rsp_ine_d;
      rsp_ne           <= rsp_ne_d;
      rsp_index        <= rsp_index_d;
      rsp_entry        <= rsp_entry_d;
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: a behavioural 16-entry TLB answers the DUT's ports, and each
// operation's strobes and response are predicted from the operation rules.
module tb_tlb_ctrl;

  typedef struct packed {
    logic        e;
    logic [5:0]  ps;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_invop;
  logic [9:0]  req_asid;
  logic [31:0] req_va;
  logic [10:0] csr_tlbidx;
  logic [18:0] csr_tlbehi_vppn;
  logic [9:0]  csr_asid;
  logic [26:0] csr_elo0, csr_elo1;
  logic        csr_refill;
  logic [18:0] tlb_s_vppn;
  logic        tlb_s_va_bit12;
  logic [9:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [3:0]  tlb_s_index, tlb_r_index, tlb_w_index, rsp_index;
  logic [88:0] tlb_r_entry, tlb_w_entry, rsp_entry;
  logic        tlb_we, tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;
  logic        rsp_valid, rsp_ready, rsp_ine, rsp_ne;
  logic [2:0]  rsp_op;

  ent_t        mem [16];
  logic        clr;
  int unsigned cyc;
  int          errors = 0;
  int          checks = 0;

  tlb_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_invop(req_invop),
    .req_asid(req_asid), .req_va(req_va),
    .csr_tlbidx(csr_tlbidx), .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_asid(csr_asid),
    .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_refill(csr_refill),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_va_bit12(tlb_s_va_bit12), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_ine(rsp_ine),
    .rsp_ne(rsp_ne), .rsp_index(rsp_index), .rsp_entry(rsp_entry)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the fill index in any cycle is this mod 16.
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic inv_hit(input ent_t en, input logic [4:0] op,
                                   input logic [9:0] a, input logic [18:0] v);
    logic am, vm;
    am = (en.asid == a);
    vm = (en.vppn == v);
    case (op)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = en.g;
      5'd3:       inv_hit = !en.g;
      5'd4:       inv_hit = !en.g && am;
      5'd5:       inv_hit = !en.g && am && vm;
      5'd6:       inv_hit = (en.g || am) && vm;
      default:    inv_hit = 1'b0;
    endcase
  endfunction

  function automatic void lookup(input logic [18:0] v, input logic [9:0] a,
                                 output logic hit, output logic [3:0] idx);
    hit = 1'b0;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (mem[i].e && mem[i].vppn == v && (mem[i].g || mem[i].asid == a)) begin
        hit = 1'b1;
        idx = 4'(i);
      end
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (tlb_we) mem[tlb_w_index] <= ent_t'(tlb_w_entry);
      if (tlb_invtlb_valid)
        for (int i = 0; i < 16; i++)
          if (inv_hit(mem[i], tlb_invtlb_op, tlb_s_asid, tlb_s_vppn)) mem[i].e <= 1'b0;
    end
  end

  always_comb lookup(tlb_s_vppn, tlb_s_asid, tlb_s_found, tlb_s_index);
  assign tlb_r_entry = mem[tlb_r_index];

  task automatic scramble();
    req_op          = 3'($urandom);
    req_invop       = 5'($urandom);
    req_asid        = 10'($urandom);
    req_va          = $urandom;
    csr_tlbidx      = 11'($urandom);
    csr_tlbehi_vppn = 19'($urandom);
    csr_asid        = 10'($urandom);
    csr_elo0        = 27'($urandom);
    csr_elo1        = 27'($urandom);
    csr_refill      = 1'($urandom);
  endtask

  // Issues the operation currently on the req/csr inputs; rsp_ready held low for 'hold' cycles.
  task automatic run_op(input int hold);
    ent_t        wexp;
    logic        hit, is_wr, is_inv, ill, e_ne, e_bit12;
    logic [3:0]  hidx, idx, e_idx, wtgt;
    logic [88:0] e_ent;
    logic [18:0] e_svppn;
    logic [9:0]  e_sasid;
    logic [2:0]  op;
    logic [4:0]  invop;
    int          n;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
    op     = req_op;
    invop  = req_invop;
    idx    = csr_tlbidx[3:0];
    is_wr  = (op == 3'd2) || (op == 3'd3);
    is_inv = (op == 3'd4) && (invop <= 5'd6);
    ill    = (op > 3'd4) || ((op == 3'd4) && !is_inv);
    wexp.e    = csr_refill || !csr_tlbidx[10];
    wexp.ps   = csr_tlbidx[9:4];
    wexp.vppn = csr_tlbehi_vppn;
    wexp.asid = csr_asid;
    wexp.g    = csr_elo0[6] && csr_elo1[6];
    wexp.ppn0 = csr_elo0[26:7];
    wexp.plv0 = csr_elo0[5:4];
    wexp.mat0 = csr_elo0[3:2];
    wexp.d0   = csr_elo0[1];
    wexp.v0   = csr_elo0[0];
    wexp.ppn1 = csr_elo1[26:7];
    wexp.plv1 = csr_elo1[5:4];
    wexp.mat1 = csr_elo1[3:2];
    wexp.d1   = csr_elo1[1];
    wexp.v1   = csr_elo1[0];
    lookup(csr_tlbehi_vppn, csr_asid, hit, hidx);
    e_ne = 1'b0; e_idx = 4'd0; e_ent = '0;
    e_svppn = '0; e_bit12 = 1'b0; e_sasid = '0;
    if (op == 3'd0) begin
      e_ne = !hit;
      e_idx = hit ? hidx : 4'd0;
      e_svppn = csr_tlbehi_vppn;
      e_sasid = csr_asid;
    end
    if (op == 3'd1) begin
      e_ne = !mem[idx].e;
      if (mem[idx].e) e_ent = mem[idx];
    end
    if (is_inv) begin
      e_svppn = req_va[31:13];
      e_bit12 = req_va[12];
      e_sasid = req_asid;
    end
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wtgt = (op == 3'd3) ? 4'(cyc) : idx;
    chk("exec_req_ready", 128'(req_ready), 128'(1'b0));
    chk("exec_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("exec_we", 128'(tlb_we), 128'(is_wr));
    chk("exec_inv_valid", 128'(tlb_invtlb_valid), 128'(is_inv));
    chk("exec_s_vppn", 128'(tlb_s_vppn), 128'(e_svppn));
    chk("exec_s_bit12", 128'(tlb_s_va_bit12), 128'(e_bit12));
    chk("exec_s_asid", 128'(tlb_s_asid), 128'(e_sasid));
    if (is_wr) begin
      chk("exec_w_index", 128'(tlb_w_index), 128'(wtgt));
      chk("exec_w_entry", 128'(tlb_w_entry), 128'(wexp));
    end
    if (is_inv) chk("exec_inv_op", 128'(tlb_invtlb_op), 128'(invop));
    if (op == 3'd1) chk("exec_r_index", 128'(tlb_r_index), 128'(idx));
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    scramble();
    @(negedge clk);
    if (is_wr) chk("tlb_written", 128'(mem[wtgt]), 128'(wexp));
    for (int k = 0; k <= hold; k++) begin
      chk("rsp_valid", 128'(rsp_valid), 128'(1'b1));
      chk("rsp_op", 128'(rsp_op), 128'(op));
      chk("rsp_ine", 128'(rsp_ine), 128'(ill));
      chk("rsp_ne", 128'(rsp_ne), 128'(e_ne));
      chk("rsp_index", 128'(rsp_index), 128'(e_idx));
      chk("rsp_entry", 128'(rsp_entry), 128'(e_ent));
      chk("resp_req_ready", 128'(req_ready), 128'(1'b0));
      chk("resp_strobes", 128'({tlb_we, tlb_invtlb_valid}), 128'(2'b00));
      chk("resp_search", 128'({tlb_s_vppn, tlb_s_va_bit12, tlb_s_asid}), 128'(0));
      if (k == hold) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    chk("done_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("done_req_ready", 128'(req_ready), 128'(1'b1));
    rsp_ready = 1'b0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [10:0] tlbidx, input logic [18:0] vppn,
                        input logic [9:0] asid, input logic [26:0] elo0, input logic [26:0] elo1,
                        input logic refill);
    req_op          = op;
    csr_tlbidx      = tlbidx;
    csr_tlbehi_vppn = vppn;
    csr_asid        = asid;
    csr_elo0        = elo0;
    csr_elo1        = elo1;
    csr_refill      = refill;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t        saved;
    logic [26:0] elo_a, elo_b;
    int          n;
    resetn = 1'b0; clr = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("rst_strobes", 128'({tlb_we, tlb_invtlb_valid}), 128'(2'b00));
    chk("rst_search", 128'({tlb_s_vppn, tlb_s_va_bit12, tlb_s_asid}), 128'(0));
    chk("rst_rsp_fields", 128'({rsp_op, rsp_ine, rsp_ne, rsp_index, rsp_entry}), 128'(0));
    clr = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // WR idx 5 with global page, then read it back and search it.
    elo_a = {20'hABCDE, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
    elo_b = {20'h00000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    set_op(3'd2, {1'b0, 6'h0C, 4'd5}, 19'h12345, 10'h3A, elo_a, elo_b, 1'b0);
    run_op(0);
    chk("wr5_e", 128'(mem[5].e), 128'(1'b1));
    chk("wr5_g", 128'(mem[5].g), 128'(1'b1));
    chk("wr5_ppn0", 128'(mem[5].ppn0), 128'(20'hABCDE));
    set_op(3'd1, {1'b0, 6'h00, 4'd5}, 19'h0, 10'h0, 27'h0, 27'h0, 1'b0);
    run_op(0);
    set_op(3'd0, 11'h0, 19'h12345, 10'h3A, 27'h0, 27'h0, 1'b0);
    run_op(0);

    // Same entry as non-global, searched under a foreign ASID.
    elo_b = {20'h00000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    set_op(3'd2, {1'b0, 6'h0C, 4'd5}, 19'h12345, 10'h3A, elo_a, elo_b, 1'b0);
    run_op(0);
    set_op(3'd0, 11'h0, 19'h12345, 10'h01, 27'h0, 27'h0, 1'b0);
    run_op(0);

    // FILL landing on counter value 15, then again 20 cycles later.
    n = 0;
    while (4'(cyc) != 4'd14 && n < 32) begin
      @(negedge clk);
      n++;
    end
    set_op(3'd3, {1'b1, 6'h15, 4'd2}, 19'h00777, 10'h3A, elo_a, elo_a, 1'b1);
    run_op(0);
    chk("fill15_e", 128'(mem[15].e), 128'(1'b1));
    repeat (20) @(negedge clk);
    set_op(3'd3, {1'b1, 6'h0C, 4'd2}, 19'h00778, 10'h02, elo_b, elo_b, 1'b0);
    run_op(0);

    // INVTLB op 5 and an out-of-range op 7.
    req_invop = 5'd5; req_asid = 10'h3A; req_va = 32'h2468A000;
    req_op = 3'd4;
    run_op(0);
    chk("inv5_cleared", 128'(mem[5].e), 128'(1'b0));
    req_invop = 5'd7;
    req_op = 3'd4;
    run_op(0);
    set_op(3'd6, 11'h0, 19'h0, 10'h0, 27'h0, 27'h0, 1'b0);
    run_op(0);

    // Backpressure on a read.
    set_op(3'd1, {1'b0, 6'h00, 4'd15}, 19'h0, 10'h0, 27'h0, 27'h0, 1'b0);
    run_op(10);

    // Reset while a write sits in EXEC.
    set_op(3'd2, {1'b0, 6'h0C, 4'd9}, 19'h55555, 10'h11, elo_a, elo_a, 1'b0);
    saved = mem[9];
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_we_before", 128'(tlb_we), 128'(1'b1));
    resetn = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midrst_we", 128'(tlb_we), 128'(1'b0));
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("midrst_req_ready", 128'(req_ready), 128'(1'b1));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("postrst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("postrst_mem9", 128'(mem[9]), 128'(saved));

    // Randomised operations over a small VPPN/ASID space so searches hit.
    for (int t = 0; t < 80; t++) begin
      req_op          = 3'($urandom_range(0, 7));
      req_invop       = 5'($urandom_range(0, 8));
      req_asid        = 10'($urandom_range(0, 3));
      req_va          = {19'($urandom_range(0, 3)), 13'($urandom)};
      csr_asid        = 10'($urandom_range(0, 3));
      csr_tlbehi_vppn = 19'($urandom_range(0, 3));
      csr_tlbidx      = 11'($urandom);
      csr_elo0        = 27'($urandom);
      csr_elo1        = 27'($urandom);
      csr_refill      = 1'($urandom);
      run_op(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
